keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//   Scans a 4x4 matrix keypad, the input-side counterpart of the 7-seg scan driver.
//   - Drives one active-low column at a time and reads the active-low rows.
//   - Debounces the result over whole scan frames.
//   - Emits a 4-bit key code with a one-cycle valid strobe.
//   - The code feeds the BCD registers that the display driver shows.
// PARAMETERS
//   SCAN_DIV        1000  clk cycles per column slot; must be >= 4
//   DEBOUNCE_FRAMES 4     identical consecutive frames to accept a press or release; must be >= 2
//   REPEAT_FRAMES   64    frames between auto-repeat strobes (used only with KEYPAD_SCAN_REPEAT_EN)
// PORTS
//   clk        in   1  system clock
//   rst        in   1  asynchronous, active-high reset
//   ROW        in   4  keypad rows, active-low, externally pulled up, asynchronous to clk
//   COL        out  4  column strobes, one-hot active-low
//   KEY        out  4  last accepted key code = col_index*4 + row_index
//   KEY_VALID  out  1  one-cycle pulse when KEY is updated (or repeated)
//   KEY_HELD   out  1  high while the accepted key is debounced-pressed
// BEHAVIOUR
// - Reset (async, immediate, also mid-operation): COL=4'b1110, KEY=0, KEY_VALID=0, KEY_HELD=0.
//   State=IDLE; all counters 0.
// - Column rotation
//   - Sequence 1110->1101->1011->0111->1110, advancing every SCAN_DIV cycles.
//   - col_index = 0,1,2,3 for those patterns; row_index = bit position of the low ROW bit.
// - Synchronizer: ROW passes a 2-flop synchronizer.
// - Sampling: the synchronized ROW is sampled on the last cycle of each slot (slot counter == SCAN_DIV-1).
// - Frame = 4 slots. At frame end the result is one of:
//   - NONE: no low row bit.
//   - SINGLE(code): exactly one low bit in exactly one slot.
//   - MULTI: anything else.
// - FSM, evaluated only at frame end:
//   - IDLE:     SINGLE -> cand<=code, cnt<=1, go DEBOUNCE. NONE/MULTI -> stay.
//   - DEBOUNCE: SINGLE(cand) -> cnt++.
//       - When cnt reaches DEBOUNCE_FRAMES: KEY<=cand, KEY_VALID=1 for one cycle, KEY_HELD<=1, go PRESSED.
//       - Any other result -> IDLE, cnt<=0.
//   - PRESSED:  NONE -> cnt<=1, go RELEASE. SINGLE/MULTI -> stay; no new strobe.
//   - RELEASE:  NONE -> cnt++.
//       - When cnt reaches DEBOUNCE_FRAMES: KEY_HELD<=0, go IDLE.
//       - SINGLE/MULTI -> back to PRESSED, no strobe.
// - Latency: KEY/KEY_VALID/KEY_HELD change on the clk edge after the frame-end sample that completes the count.
// - KEY holds its value after release until the next accepted press.
// - A new key pressed while another is held gives no strobe. It is accepted only after a full release and a new debounce.
// - Counters saturate; no wrap of cnt or repeat counters.
// CONFIGURATION
//   KEYPAD_SCAN_REPEAT_EN
//   - Defined: while in PRESSED with frame result SINGLE(KEY), a repeat counter increments per frame.
//     - On reaching REPEAT_FRAMES it pulses KEY_VALID (KEY unchanged) and clears.
//     - It clears on entry to PRESSED and on any non-matching frame.
//   - Undefined: no repeat logic; exactly one KEY_VALID per accepted press.
// TESTING (SCAN_DIV=4, DEBOUNCE_FRAMES=3, REPEAT_FRAMES=2; frame = 16 clk)
//   1. Assert rst -> COL=1110, KEY=0, KEY_VALID=0, KEY_HELD=0.
//      Release -> COL steps 1101,1011,0111,1110 every 4 clk.
//   2. Drive ROW[2]=0 only while COL=1101, steady -> one KEY_VALID pulse with KEY=4'd6, KEY_HELD=1.
//      The pulse follows the 3rd frame end.
//   3. Press key 6 for 1 frame, release 1 frame, press 2 frames, release -> no KEY_VALID; KEY stays 0.
//   4. Keys 6 and 9 pressed together for 5 frames -> no KEY_VALID, KEY_HELD=0.
//   5. From test 2, release -> KEY_HELD=0 after 3 empty frames; KEY stays 6.
//      Press 6 again -> new KEY_VALID.
//   6. Assert rst mid-DEBOUNCE -> outputs back to reset values at once; next press needs the full 3 frames.
//   7. With KEYPAD_SCAN_REPEAT_EN, hold key 6 for 10 frames -> initial pulse, then one pulse every 2 frames.
//      Without the macro -> a single pulse only.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with frame-level debounce and one-cycle KEY_VALID strobe.
// Optional auto-repeat of the held key is compiled in with `define KEYPAD_SCAN_REPEAT_EN.
module keypad_scan #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
`ifdef KEYPAD_SCAN_REPEAT_EN
    ,
    parameter int unsigned REPEAT_FRAMES   = 64
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY,
    output logic       KEY_VALID,
    output logic       KEY_HELD
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_FRAMES);
`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] REP_DONE = RW'(REPEAT_FRAMES);
`endif

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    row_meta_q, row_meta_d;
    logic [3:0]    row_sync_q, row_sync_d;
    logic [1:0]    hits_q, hits_d;
    logic [3:0]    code_q, code_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;
`ifdef KEYPAD_SCAN_REPEAT_EN
    logic [RW-1:0] rep_q, rep_d;
    logic [RW-1:0] rep_inc;
`endif

    logic          slot_end, frame_end;
    logic [1:0]    slot_hits, slot_row;
    logic [2:0]    tot_hits;
    logic [3:0]    res_code;
    res_t          frame_res;
    logic [CW-1:0] cnt_inc;

    assign slot_end  = (slot_q == SLOT_LAST);
    assign frame_end = slot_end && (col_q == 2'd3);
    assign tot_hits  = {1'b0, hits_q} + {1'b0, slot_hits};
    assign cnt_inc   = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + CW'(1);
`ifdef KEYPAD_SCAN_REPEAT_EN
    assign rep_inc   = (rep_q == REP_DONE) ? rep_q : rep_q + RW'(1);
`endif

    // Low-row count for the current slot, saturating at 2 (anything >1 is MULTI anyway)
    always_comb begin
        slot_hits = 2'd0;
        slot_row  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!row_sync_q[i]) begin
                slot_row = 2'(i);
                if (slot_hits != 2'd2) slot_hits = slot_hits + 2'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_end ? '0 : slot_q + SW'(1);
        col_d      = slot_end ? col_q + 2'd1 : col_q;
        row_meta_d = ROW;
        row_sync_d = row_meta_q;
        hits_d     = hits_q;
        code_d     = code_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        valid_d    = 1'b0;
        held_d     = held_q;
`ifdef KEYPAD_SCAN_REPEAT_EN
        rep_d      = rep_q;
`endif
        res_code   = (slot_hits != 2'd0) ? {col_q, slot_row} : code_q;
        frame_res  = RES_NONE;

        if (slot_end) begin
            hits_d = (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
            code_d = res_code;
        end

        if (frame_end) begin
            hits_d = 2'd0;
            code_d = 4'd0;
            if (tot_hits == 3'd0)      frame_res = RES_NONE;
            else if (tot_hits == 3'd1) frame_res = RES_SINGLE;
            else                       frame_res = RES_MULTI;

            unique case (state_q)
                IDLE: begin
                    if (frame_res == RES_SINGLE) begin
                        cand_d  = res_code;
                        cnt_d   = CW'(1);
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (frame_res == RES_SINGLE && res_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            key_d   = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = PRESSED;
`ifdef KEYPAD_SCAN_REPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (frame_res == RES_NONE) begin
                        cnt_d   = CW'(1);
                        state_d = RELEASE;
`ifdef KEYPAD_SCAN_REPEAT_EN
                        rep_d   = '0;
                    end else if (frame_res == RES_SINGLE && res_code == key_q) begin
                        rep_d = rep_inc;
                        if (rep_inc == REP_DONE) begin
                            valid_d = 1'b1;
                            rep_d   = '0;
                        end
                    end else begin
                        rep_d = '0;
`endif
                    end
                end
                RELEASE: begin
                    if (frame_res == RES_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            held_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        // A bounce back to pressed: the same press continues, no new strobe
                        cnt_d   = '0;
                        state_d = PRESSED;
`ifdef KEYPAD_SCAN_REPEAT_EN
                        rep_d   = '0;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            col_q      <= 2'd0;
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            hits_q     <= 2'd0;
            code_q     <= 4'd0;
            cand_q     <= 4'd0;
            cnt_q      <= '0;
            key_q      <= 4'd0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
            rep_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            col_q      <= col_d;
            row_meta_q <= row_meta_d;
            row_sync_q <= row_sync_d;
            hits_q     <= hits_d;
            code_q     <= code_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
`ifdef KEYPAD_SCAN_REPEAT_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign COL       = ~(4'b0001 << col_q);
    assign KEY       = key_q;
    assign KEY_VALID = valid_q;
    assign KEY_HELD  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: keypad matrix model, strobe scoreboard, immediate-assert checks.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic [3:0]  KEY;
    logic        KEY_VALID;
    logic        KEY_HELD;
    logic [15:0] keys = 16'h0;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    keypad_scan #(
        .SCAN_DIV(4),
        .DEBOUNCE_FRAMES(3)
`ifdef KEYPAD_SCAN_REPEAT_EN
        ,
        .REPEAT_FRAMES(2)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .ROW(ROW),
        .COL(COL),
        .KEY(KEY),
        .KEY_VALID(KEY_VALID),
        .KEY_HELD(KEY_HELD)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven
    always_comb begin
        logic [1:0] col_i;
        ROW   = 4'hF;
        col_i = 2'd0;
        case (COL)
            4'b1110: col_i = 2'd0;
            4'b1101: col_i = 2'd1;
            4'b1011: col_i = 2'd2;
            4'b0111: col_i = 2'd3;
            default: col_i = 2'd0;
        endcase
        for (int r = 0; r < 4; r++)
            if (keys[{col_i, 2'(r)}]) ROW[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_frames(input int n);
        repeat (16 * n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        keys = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard: every strobe must match the next queued key code
    always @(negedge clk) begin
        if (!rst && KEY_VALID) begin
            if (exp_q.size() == 0) check("strobe_unexpected", 8'(KEY_VALID), 8'd0);
            else                   check("strobe_key", 8'(KEY), 8'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [3:0] col_seq [4];
        logic       exp_v;
        col_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // 1: reset values and column rotation
        repeat (2) @(negedge clk);
        check("rst_col", 8'(COL), 8'hE);
        check("rst_key", 8'(KEY), 8'h0);
        check("rst_valid", 8'(KEY_VALID), 8'h0);
        check("rst_held", 8'(KEY_HELD), 8'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clk);
            check($sformatf("col_step%0d", i), 8'(COL), 8'(col_seq[i]));
        end

        // 2: steady press of key 6 accepted at the 3rd frame end
        do_reset();
        keys[6] = 1'b1;
        exp_q.push_back(4'd6);
        run_frames(2);
        check("t2_no_early_valid", 8'(KEY_VALID), 8'h0);
        check("t2_no_early_held", 8'(KEY_HELD), 8'h0);
        run_frames(1);
        check("t2_valid", 8'(KEY_VALID), 8'h1);
        check("t2_key", 8'(KEY), 8'h6);
        check("t2_held", 8'(KEY_HELD), 8'h1);

        // 5: release debounce, KEY retained, re-press gives a new strobe
        keys = 16'h0;
        @(negedge clk);
        check("t2_pulse_width", 8'(KEY_VALID), 8'h0);
        check("t2_drained", 8'(exp_q.size()), 8'd0);
        repeat (15) @(negedge clk);
        check("t5_held_f1", 8'(KEY_HELD), 8'h1);
        run_frames(1);
        check("t5_held_f2", 8'(KEY_HELD), 8'h1);
        run_frames(1);
        check("t5_released", 8'(KEY_HELD), 8'h0);
        check("t5_key_kept", 8'(KEY), 8'h6);
        keys[6] = 1'b1;
        exp_q.push_back(4'd6);
        run_frames(2);
        check("t5_no_early", 8'(KEY_VALID), 8'h0);
        run_frames(1);
        check("t5_repress_valid", 8'(KEY_VALID), 8'h1);
        keys = 16'h0;
        @(negedge clk);
        repeat (15) @(negedge clk);
        check("t5_drained", 8'(exp_q.size()), 8'd0);

        // 6: reset asserted mid-debounce of key 9
        run_frames(2);
        keys[9] = 1'b1;
        run_frames(2);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_async_col", 8'(COL), 8'hE);
        check("t6_async_key", 8'(KEY), 8'h0);
        check("t6_async_held", 8'(KEY_HELD), 8'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(4'd9);
        run_frames(2);
        check("t6_needs_full", 8'(KEY_VALID), 8'h0);
        run_frames(1);
        check("t6_valid", 8'(KEY_VALID), 8'h1);
        check("t6_key", 8'(KEY), 8'h9);
        keys = 16'h0;
        @(negedge clk);
        check("t6_drained", 8'(exp_q.size()), 8'd0);

        // 3: bouncy press never completes a debounce
        do_reset();
        keys[6] = 1'b1; run_frames(1);
        keys = 16'h0;   run_frames(1);
        keys[6] = 1'b1; run_frames(2);
        keys = 16'h0;   run_frames(2);
        check("t3_key", 8'(KEY), 8'h0);
        check("t3_held", 8'(KEY_HELD), 8'h0);

        // 4: two keys together are MULTI, never accepted
        do_reset();
        keys[6] = 1'b1;
        keys[9] = 1'b1;
        run_frames(5);
        check("t4_key", 8'(KEY), 8'h0);
        check("t4_held", 8'(KEY_HELD), 8'h0);
        keys = 16'h0;

        // 7: long hold; auto-repeat every 2 frames only when compiled in
        do_reset();
        keys[6] = 1'b1;
        for (int f = 1; f <= 10; f++) begin
            exp_v = (f == 3);
`ifdef KEYPAD_SCAN_REPEAT_EN
            exp_v = exp_v || f == 5 || f == 7 || f == 9;
`endif
            if (exp_v) exp_q.push_back(4'd6);
            run_frames(1);
            check($sformatf("t7_frame%0d_valid", f), 8'(KEY_VALID), 8'(exp_v));
        end
        keys = 16'h0;
        run_frames(4);
        check("t7_held_off", 8'(KEY_HELD), 8'h0);
        check("t7_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
